// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline boundary registers: exception codes,
// payload lane indices and the per-edge action decode.
package pipe_pkg;

    localparam logic [31:0] EXC_VEC_DEFAULT = 32'h0000_4180;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int LANE_ALU = 0;
    localparam int LANE_DM  = 1;
    localparam int LANE_MDU = 2;
    localparam int LANE_CP0 = 3;

    typedef enum logic [1:0] {
        ACT_LOAD  = 2'd0,
        ACT_STALL = 2'd1,
        ACT_FLUSH = 2'd2,
        ACT_INT   = 2'd3
    } stage_act_e;

    // Reset is handled separately by each register; this ranks the remaining controls.
    function automatic stage_act_e decode_act(input logic int_req,
                                              input logic flush,
                                              input logic stall);
        if (int_req)
            return ACT_INT;
        else if (flush)
            return ACT_FLUSH;
        else if (stall)
            return ACT_STALL;
        else
            return ACT_LOAD;
    endfunction

endpackage

// File: rtl/perf_sat_counter.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module perf_sat_counter (
    input  logic        clk,
    input  logic        clear,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] count_reg;

    always_ff @(posedge clk) begin
        if (clear)
            count_reg <= '0;
        else if (inc && (count_reg != 32'hFFFF_FFFF))
            count_reg <= count_reg + 32'd1;
    end

    assign count = count_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall, flush and exception-redirect bubbles.
// Define STAGE_PERF_EN to build the stall/bubble saturating counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                  LANES         = 4,
    parameter int                  DATA_W        = 32,
    parameter int                  PC_W          = 32,
    parameter logic [PC_W-1:0]     RESET_PC      = '0,
    parameter logic [PC_W-1:0]     EXC_VEC       = PC_W'(EXC_VEC_DEFAULT),
    parameter logic [LANES-1:0]    LANE_CLR_MASK = {LANES{1'b1}}
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    int_req,
    input  logic                    flush,
    input  logic                    stall,
    input  logic                    in_valid,
    input  logic [31:0]             in_instr,
    input  logic [PC_W-1:0]         in_pc,
    input  logic [4:0]              in_exc,
    input  logic                    in_bd,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic                    out_valid,
    output logic [31:0]             out_instr,
    output logic [PC_W-1:0]         out_pc,
    output logic [4:0]              out_exc,
    output logic                    out_bd,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [31:0]             perf_stall_cnt,
    output logic [31:0]             perf_bubble_cnt
);

    stage_act_e act;

    logic            valid_reg;
    logic [31:0]     instr_reg;
    logic [PC_W-1:0] pc_reg;
    logic [4:0]      exc_reg;
    logic            bd_reg;

    always_comb begin
        act = decode_act(int_req, flush, stall);
    end

    // Control fields: bubbles keep a meaningful PC/BD so CP0 can still report EPC.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg <= 1'b0;
            instr_reg <= '0;
            pc_reg    <= RESET_PC;
            exc_reg   <= EXC_NONE;
            bd_reg    <= 1'b0;
        end else begin
            case (act)
                ACT_INT: begin
                    valid_reg <= 1'b0;
                    instr_reg <= '0;
                    pc_reg    <= EXC_VEC;
                    exc_reg   <= EXC_NONE;
                    bd_reg    <= 1'b0;
                end
                ACT_FLUSH: begin
                    valid_reg <= 1'b0;
                    instr_reg <= '0;
                    pc_reg    <= in_pc;
                    exc_reg   <= EXC_NONE;
                    bd_reg    <= in_bd;
                end
                ACT_STALL: begin
                end
                default: begin
                    valid_reg <= in_valid;
                    instr_reg <= in_valid ? in_instr : 32'd0;
                    pc_reg    <= in_pc;
                    exc_reg   <= in_valid ? in_exc : EXC_NONE;
                    bd_reg    <= in_bd;
                end
            endcase
        end
    end

    assign out_valid = valid_reg;
    assign out_instr = instr_reg;
    assign out_pc    = pc_reg;
    assign out_exc   = exc_reg;
    assign out_bd    = bd_reg;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [DATA_W-1:0] lane_reg;

            // Lanes with a clear mask of 0 carry state across bubbles (e.g. pending MDU results).
            always_ff @(posedge clk) begin
                if (reset) begin
                    lane_reg <= '0;
                end else if ((act == ACT_INT) || (act == ACT_FLUSH)) begin
                    if (LANE_CLR_MASK[gi])
                        lane_reg <= '0;
                end else if (act == ACT_LOAD) begin
                    lane_reg <= in_data[gi*DATA_W +: DATA_W];
                end
            end

            assign out_data[gi*DATA_W +: DATA_W] = lane_reg;
        end
    endgenerate

`ifdef STAGE_PERF_EN
    logic stall_evt;
    logic bubble_evt;

    assign stall_evt  = (act == ACT_STALL);
    assign bubble_evt = (act == ACT_INT) || (act == ACT_FLUSH) ||
                        ((act == ACT_LOAD) && !in_valid);

    perf_sat_counter u_stall_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (stall_evt),
        .count (perf_stall_cnt)
    );

    perf_sat_counter u_bubble_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (bubble_evt),
        .count (perf_bubble_cnt)
    );
`else
    assign perf_stall_cnt  = 32'd0;
    assign perf_bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed table plus randomized run against a reference model,
// on two instances (full lane clear mask and mask 4'b0111).
module tb_pipe_stage_reg;

`ifdef STAGE_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    typedef struct packed {
        logic         reset;
        logic         int_req;
        logic         flush;
        logic         stall;
        logic         valid;
        logic [31:0]  instr;
        logic [31:0]  pc;
        logic [4:0]   exc;
        logic         bd;
        logic [127:0] data;
    } stim_t;

    typedef struct packed {
        logic         valid;
        logic [31:0]  instr;
        logic [31:0]  pc;
        logic [4:0]   exc;
        logic         bd;
        logic [127:0] data;
        logic [31:0]  stall_cnt;
        logic [31:0]  bubble_cnt;
    } mstate_t;

    typedef struct packed {
        stim_t        s;
        mstate_t      e;
        logic [127:0] data_m;
    } row_t;

    logic         clk = 1'b0;
    logic         reset, int_req, flush, stall, in_valid, in_bd;
    logic [31:0]  in_instr, in_pc;
    logic [4:0]   in_exc;
    logic [127:0] in_data;

    logic         o0_valid, o0_bd, o1_valid, o1_bd;
    logic [31:0]  o0_instr, o0_pc, o1_instr, o1_pc;
    logic [4:0]   o0_exc, o1_exc;
    logic [127:0] o0_data, o1_data;
    logic [31:0]  o0_sc, o0_bc, o1_sc, o1_bc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut0 (
        .clk(clk), .reset(reset), .int_req(int_req), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_exc(in_exc),
        .in_bd(in_bd), .in_data(in_data),
        .out_valid(o0_valid), .out_instr(o0_instr), .out_pc(o0_pc), .out_exc(o0_exc),
        .out_bd(o0_bd), .out_data(o0_data),
        .perf_stall_cnt(o0_sc), .perf_bubble_cnt(o0_bc)
    );

    pipe_stage_reg #(.LANE_CLR_MASK(4'b0111)) dut1 (
        .clk(clk), .reset(reset), .int_req(int_req), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_exc(in_exc),
        .in_bd(in_bd), .in_data(in_data),
        .out_valid(o1_valid), .out_instr(o1_instr), .out_pc(o1_pc), .out_exc(o1_exc),
        .out_bd(o1_bd), .out_data(o1_data),
        .perf_stall_cnt(o1_sc), .perf_bubble_cnt(o1_bc)
    );

    function automatic stim_t mk_stim(logic r, logic ir, logic fl, logic st, logic v,
                                      logic [31:0] instr, logic [31:0] pc, logic [4:0] exc,
                                      logic bd, logic [127:0] data);
        stim_t s;
        s.reset = r; s.int_req = ir; s.flush = fl; s.stall = st; s.valid = v;
        s.instr = instr; s.pc = pc; s.exc = exc; s.bd = bd; s.data = data;
        return s;
    endfunction

    function automatic mstate_t mk_exp(logic v, logic [31:0] instr, logic [31:0] pc,
                                       logic [4:0] exc, logic bd, logic [127:0] data,
                                       logic [31:0] sc, logic [31:0] bc);
        mstate_t e;
        e.valid = v; e.instr = instr; e.pc = pc; e.exc = exc; e.bd = bd; e.data = data;
        e.stall_cnt = sc; e.bubble_cnt = bc;
        return e;
    endfunction

    function automatic logic [31:0] sat_inc(logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Reference: what the stage holds after one edge, from the priority rules.
    function automatic mstate_t model_step(mstate_t cur, stim_t in, logic [3:0] mask);
        mstate_t n = cur;
        if (in.reset) begin
            n = '0;
        end else if (in.int_req || in.flush) begin
            n.valid = 1'b0;
            n.instr = 32'd0;
            n.exc   = 5'd0;
            n.pc    = in.int_req ? 32'h0000_4180 : in.pc;
            n.bd    = in.int_req ? 1'b0 : in.bd;
            for (int i = 0; i < 4; i++)
                if (mask[i]) n.data[i*32 +: 32] = 32'd0;
            n.bubble_cnt = sat_inc(cur.bubble_cnt);
        end else if (in.stall) begin
            n.stall_cnt = sat_inc(cur.stall_cnt);
        end else begin
            n.valid = in.valid;
            n.instr = in.valid ? in.instr : 32'd0;
            n.exc   = in.valid ? in.exc : 5'd0;
            n.pc    = in.pc;
            n.bd    = in.bd;
            n.data  = in.data;
            if (!in.valid) n.bubble_cnt = sat_inc(cur.bubble_cnt);
        end
        return n;
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic compare_state(string tag, mstate_t a, mstate_t e);
        if (!PERF_EN) begin
            e.stall_cnt  = 32'd0;
            e.bubble_cnt = 32'd0;
        end
        chk({tag, ".valid"},  128'(a.valid),      128'(e.valid));
        chk({tag, ".instr"},  128'(a.instr),      128'(e.instr));
        chk({tag, ".pc"},     128'(a.pc),         128'(e.pc));
        chk({tag, ".exc"},    128'(a.exc),        128'(e.exc));
        chk({tag, ".bd"},     128'(a.bd),         128'(e.bd));
        chk({tag, ".data"},   a.data,             e.data);
        chk({tag, ".stalls"}, 128'(a.stall_cnt),  128'(e.stall_cnt));
        chk({tag, ".bubbles"},128'(a.bubble_cnt), 128'(e.bubble_cnt));
    endtask

    function automatic mstate_t get0();
        return mk_exp(o0_valid, o0_instr, o0_pc, o0_exc, o0_bd, o0_data, o0_sc, o0_bc);
    endfunction

    function automatic mstate_t get1();
        return mk_exp(o1_valid, o1_instr, o1_pc, o1_exc, o1_bd, o1_data, o1_sc, o1_bc);
    endfunction

    task automatic apply(stim_t s);
        reset = s.reset; int_req = s.int_req; flush = s.flush; stall = s.stall;
        in_valid = s.valid; in_instr = s.instr; in_pc = s.pc; in_exc = s.exc;
        in_bd = s.bd; in_data = s.data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] D_1234 = {32'd4, 32'd3, 32'd2, 32'd1};
    localparam logic [127:0] D_5678 = {32'd8, 32'd7, 32'd6, 32'd5};
    localparam logic [127:0] D_9ABC = {32'hC, 32'hB, 32'hA, 32'h9};
    localparam logic [127:0] D_1144 = {32'h44, 32'h33, 32'h22, 32'h11};
    localparam logic [127:0] D_5588 = {32'h88, 32'h77, 32'h66, 32'h55};

    row_t    tbl[13];
    mstate_t m0, m1, e1;
    stim_t   rs;

    initial begin
        // reset x2, load valid, load invalid, load, stall x3, flush+stall, load,
        // int+flush+stall, load, reset+int
        tbl[0]  = '{mk_stim(1,0,0,0,1,32'h1111_1111,32'h5555_5554,5'd3,1,{4{32'hA5A5_A5A5}}),
                    mk_exp(0,0,32'h0,0,0,128'd0,0,0), 128'd0};
        tbl[1]  = '{mk_stim(1,0,1,1,1,32'h2222_2222,32'h6666_6664,5'd7,1,{4{32'h5A5A_5A5A}}),
                    mk_exp(0,0,32'h0,0,0,128'd0,0,0), 128'd0};
        tbl[2]  = '{mk_stim(0,0,0,0,1,32'h2408_0005,32'h3004,5'd0,0,D_1234),
                    mk_exp(1,32'h2408_0005,32'h3004,0,0,D_1234,0,0), D_1234};
        tbl[3]  = '{mk_stim(0,0,0,0,0,32'hDEAD_BEEF,32'h3008,5'd5,0,D_5678),
                    mk_exp(0,0,32'h3008,0,0,D_5678,0,1), D_5678};
        tbl[4]  = '{mk_stim(0,0,0,0,1,32'h8C41_0010,32'h300C,5'd0,1,D_9ABC),
                    mk_exp(1,32'h8C41_0010,32'h300C,0,1,D_9ABC,0,1), D_9ABC};
        tbl[5]  = '{mk_stim(0,0,0,1,1,32'hAAAA_0001,32'h4000,5'd4,0,D_1234),
                    mk_exp(1,32'h8C41_0010,32'h300C,0,1,D_9ABC,1,1), D_9ABC};
        tbl[6]  = '{mk_stim(0,0,0,1,0,32'hAAAA_0002,32'h4004,5'd10,0,D_5678),
                    mk_exp(1,32'h8C41_0010,32'h300C,0,1,D_9ABC,2,1), D_9ABC};
        tbl[7]  = '{mk_stim(0,0,0,1,1,32'hAAAA_0003,32'h4008,5'd12,1,D_1144),
                    mk_exp(1,32'h8C41_0010,32'h300C,0,1,D_9ABC,3,1), D_9ABC};
        tbl[8]  = '{mk_stim(0,0,1,1,1,32'h1234_5678,32'h3010,5'd4,1,D_5588),
                    mk_exp(0,0,32'h3010,0,1,128'd0,3,2), {32'hC, 96'd0}};
        tbl[9]  = '{mk_stim(0,0,0,0,1,32'h0000_000C,32'h3014,5'd10,0,D_1144),
                    mk_exp(1,32'h0000_000C,32'h3014,5'd10,0,D_1144,3,2), D_1144};
        tbl[10] = '{mk_stim(0,1,1,1,1,32'hFFFF_FFFF,32'h3018,5'd12,1,D_5678),
                    mk_exp(0,0,32'h4180,0,0,128'd0,3,3), {32'h44, 96'd0}};
        tbl[11] = '{mk_stim(0,0,0,0,1,32'h0000_0001,32'h301C,5'd0,0,D_5588),
                    mk_exp(1,32'h0000_0001,32'h301C,0,0,D_5588,3,3), D_5588};
        tbl[12] = '{mk_stim(1,1,0,1,1,32'h0000_0002,32'h3020,5'd0,1,{4{32'h1}}),
                    mk_exp(0,0,32'h0,0,0,128'd0,0,0), 128'd0};

        for (int r = 0; r < 13; r++) begin
            apply(tbl[r].s);
            tick();
            e1 = tbl[r].e;
            e1.data = tbl[r].data_m;
            compare_state($sformatf("row%0d.full", r), get0(), tbl[r].e);
            compare_state($sformatf("row%0d.mask", r), get1(), e1);
            $display("row %0d: rst=%0b int=%0b fl=%0b st=%0b v=%0b -> pc0=%h pc1=%h",
                     r, tbl[r].s.reset, tbl[r].s.int_req, tbl[r].s.flush,
                     tbl[r].s.stall, tbl[r].s.valid, o0_pc, o1_pc);
        end

        m0 = '0;
        m1 = '0;
        for (int c = 0; c < 500; c++) begin
            rs = mk_stim($urandom_range(0, 49) == 0, $urandom_range(0, 29) == 0,
                         $urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0,
                         $urandom_range(0, 3) != 0, $urandom, $urandom,
                         5'($urandom_range(0, 31)), 1'($urandom),
                         {$urandom, $urandom, $urandom, $urandom});
            apply(rs);
            tick();
            m0 = model_step(m0, rs, 4'b1111);
            m1 = model_step(m1, rs, 4'b0111);
            compare_state($sformatf("rand%0d.full", c), get0(), m0);
            compare_state($sformatf("rand%0d.mask", c), get1(), m1);
            $display("rand %0d: rst=%0b int=%0b fl=%0b st=%0b v=%0b -> v=%0b pc=%h",
                     c, rs.reset, rs.int_req, rs.flush, rs.stall, rs.valid,
                     o0_valid, o0_pc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the five-stage MIPS core (F/D, D/E, E/M, M/W boundaries).
- Carries instruction, PC, a valid bit, exception code, branch-delay flag and LANES data payloads.
- Supports stall (hold), flush (bubble with preserved PC) and interrupt/exception redirect (bubble with handler PC).
- Optional performance counters track stall and bubble cycles per stage.

Parameters:
- LANES, 4, number of DATA_W payload lanes (ALU, DM, MDU, CP0 ...).
- DATA_W, 32, width of each payload lane.
- PC_W, 32, PC width.
- RESET_PC, 32'h0000_0000, out_pc value after reset.
- EXC_VEC, 32'h0000_4180, out_pc value loaded on int_req.
- LANE_CLR_MASK, {LANES{1'b1}}, bit i=1: lane i zeroed on bubble; bit i=0: lane i holds its value on bubble.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- int_req  in  1  interrupt/exception taken; redirect bubble
- flush  in  1  insert bubble (e.g. stall-generated bubble or eret)
- stall  in  1  hold all outputs
- in_valid  in  1  upstream instruction valid
- in_instr  in  32  upstream instruction word
- in_pc  in  PC_W  upstream PC
- in_exc  in  5  upstream ExcCode (0 = none)
- in_bd  in  1  upstream instruction is in a delay slot
- in_data  in  LANES*DATA_W  payload lanes, lane i at bits [i*DATA_W +: DATA_W]
- out_valid  out  1  registered valid
- out_instr  out  32  registered instruction
- out_pc  out  PC_W  registered PC
- out_exc  out  5  registered ExcCode
- out_bd  out  1  registered delay-slot flag
- out_data  out  LANES*DATA_W  registered payloads
- perf_stall_cnt  out  32  stall cycles (STAGE_PERF_EN only)
- perf_bubble_cnt  out  32  bubble cycles (STAGE_PERF_EN only)

Behaviour:
- All updates occur on the rising edge of clk; latency is 1 cycle; there is no combinational path from inputs to outputs.
- Priority per edge: reset > int_req > flush > stall > load.
- reset:
  - out_valid=0, out_instr=0, out_pc=RESET_PC, out_exc=0, out_bd=0.
  - All lanes=0, regardless of LANE_CLR_MASK.
  - Perf counters=0.
- int_req:
  - out_valid=0, out_instr=0, out_pc=EXC_VEC, out_exc=0, out_bd=0.
  - Lanes with a mask bit of 1 are zeroed; the others hold.
  - Overrides a simultaneous stall or flush.
- flush (no int_req):
  - out_valid=0, out_instr=0, out_exc=0, lanes cleared per mask.
  - out_pc<=in_pc and out_bd<=in_bd, so the macroscopic PC/BD stays correct for CP0 EPC.
  - Overrides a simultaneous stall.
- stall (no reset, int_req or flush): every output holds, including out_valid.
- load: every out_* <= in_*. If in_valid=0, out_instr and out_exc are forced to 0 and out_valid=0; PC, BD and lanes still load.
- A stall released mid-sequence resumes with the next edge's inputs; no replay or skid storage.
- A reset asserted during stall or int_req takes effect on that edge.

Optional Feature:
- Macro: STAGE_PERF_EN.
- Defined:
  - perf_stall_cnt increments on each edge where stall=1 and no reset/int_req/flush applies.
  - perf_bubble_cnt increments on each edge where int_req, flush, or a load with in_valid=0 occurs.
  - Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are generated.

Decomposition:
- Shared package pipe_pkg holds:
  - EXC_VEC_DEFAULT = 32'h0000_4180.
  - ExcCode constants (EXC_NONE=0, EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_RI=10, EXC_OV=12).
  - Lane-index localparams per boundary (LANE_ALU, LANE_DM, LANE_MDU, LANE_CP0).
- Sub-module perf_sat_counter: 32-bit saturating counter with inc/clear, instantiated twice under STAGE_PERF_EN.

Test Plan:
- Reset: hold reset 2 cycles with random inputs -> out_pc=0, all other outputs 0, counters 0.
- Load: in_valid=1, in_instr=32'h2408_0005, in_pc=32'h3004, lanes 1,2,3,4 -> next cycle outputs match exactly; in_valid=0 on the following cycle -> out_instr=0, out_valid=0, out_pc is the new in_pc.
- Stall: stall=1 for 3 cycles while inputs change -> outputs frozen at the prior values; perf_stall_cnt=3.
- Flush with stall: flush=1, stall=1, in_pc=32'h3010, in_bd=1 -> out_instr=0, out_pc=32'h3010, out_bd=1, out_valid=0; perf_bubble_cnt +1.
- Interrupt priority: int_req=1, flush=1, stall=1, LANE_CLR_MASK=4'b0111 -> out_pc=32'h4180, lanes 0-2 zeroed, lane 3 unchanged.
- Reset during int_req: reset=1, int_req=1 -> out_pc=RESET_PC and all lanes 0.
